// File: rtl/bullet_sprite_reader_if.sv
// Bullet sprite ROM read port: the engine drives address and sprite select,
// and the ROM returns a palette index combinationally.
interface bullet_sprite_reader_if;
  logic [13:0] rom_addr;
  logic [1:0]  rom_sel;
  logic [3:0]  rom_data;

  modport master (output rom_addr, output rom_sel, input rom_data);
  modport slave  (input rom_addr, input rom_sel, output rom_data);
endinterface

// File: rtl/bullet_sprite_reader.sv
// Single-bullet flight engine and bullet sprite ROM reader; converts the scan position
// into ROM addresses and registers the returned palette index as a pixel stream.
module bullet_sprite_reader #(
  parameter int unsigned SPRITE   = 20,
  parameter int unsigned SPEED    = 4,
  parameter int unsigned LIFETIME = 120,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_tick,
  input  logic                          fire,
  input  logic                          hit,
  input  logic [9:0]                    tank_x,
  input  logic [9:0]                    tank_y,
  input  logic [1:0]                    tank_dir,
  input  logic [1:0]                    tank_sel,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  bullet_sprite_reader_if.master        rom,
  output logic                          busy,
  output logic [9:0]                    bullet_x,
  output logic [9:0]                    bullet_y,
  output logic                          pixel_on,
  output logic [3:0]                    pixel_index
);

  localparam int unsigned LifeW = (LIFETIME < 2) ? 1 : $clog2(LIFETIME + 1);

  localparam logic [10:0] Sprite11 = 11'(SPRITE);
  localparam logic [10:0] Speed11  = 11'(SPEED);
  localparam logic [10:0] MaxX11   = 11'(SCREEN_W - SPRITE);
  localparam logic [10:0] MaxY11   = 11'(SCREEN_H - SPRITE);
  localparam logic [9:0]  Speed10  = 10'(SPEED);
  localparam logic [13:0] Sprite14 = 14'(SPRITE);
  localparam logic [LifeW-1:0] LifeEnd = LifeW'(LIFETIME);

  typedef enum logic [1:0] {StIdle, StArmed, StFly} state_e;

  state_e           state_q;
  logic [9:0]       bullet_x_q, bullet_y_q;
  logic [1:0]       dir_q, sel_q;
  logic [LifeW-1:0] life_q;
  logic             pixel_on_q;
  logic [3:0]       pixel_index_q;

  logic [10:0]      x11, y11, dx11, dy11;
  logic             in_box;
  logic [9:0]       rel_x, rel_y;
  logic [LifeW-1:0] life_inc;
  logic             expire, off_screen;
  logic [9:0]       step_x, step_y;

  always_comb begin
    x11    = {1'b0, bullet_x_q};
    y11    = {1'b0, bullet_y_q};
    dx11   = {1'b0, DrawX};
    dy11   = {1'b0, DrawY};
    in_box = (state_q == StFly) &&
             (dx11 >= x11) && (dx11 < x11 + Sprite11) &&
             (dy11 >= y11) && (dy11 < y11 + Sprite11);
    rel_x  = DrawX - bullet_x_q;
    rel_y  = DrawY - bullet_y_q;
  end

  assign rom.rom_addr = in_box ? (14'(rel_y) * Sprite14 + 14'(rel_x)) : 14'd0;
  assign rom.rom_sel  = sel_q;

  // Movement candidate for the next frame tick and whether it would leave the screen.
  always_comb begin
    life_inc   = life_q + 1'b1;
    expire     = (life_inc == LifeEnd);
    off_screen = 1'b0;
    step_x     = bullet_x_q;
    step_y     = bullet_y_q;
    unique case (dir_q)
      2'b00: begin
        off_screen = (y11 < Speed11);
        step_y     = bullet_y_q - Speed10;
      end
      2'b01: begin
        off_screen = (x11 + Speed11 > MaxX11);
        step_x     = bullet_x_q + Speed10;
      end
      2'b10: begin
        off_screen = (y11 + Speed11 > MaxY11);
        step_y     = bullet_y_q + Speed10;
      end
      2'b11: begin
        off_screen = (x11 < Speed11);
        step_x     = bullet_x_q - Speed10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StIdle;
      bullet_x_q    <= '0;
      bullet_y_q    <= '0;
      dir_q         <= '0;
      sel_q         <= '0;
      life_q        <= '0;
      pixel_on_q    <= 1'b0;
      pixel_index_q <= '0;
    end else begin
      pixel_on_q    <= in_box && (rom.rom_data != 4'd0);
      pixel_index_q <= in_box ? rom.rom_data : 4'd0;
      unique case (state_q)
        StIdle: begin
          if (fire) begin
            bullet_x_q <= tank_x;
            bullet_y_q <= tank_y;
            dir_q      <= tank_dir;
            sel_q      <= tank_sel;
            state_q    <= StArmed;
          end
        end
        StArmed: begin
          if (hit) begin
            state_q <= StIdle;
          end else if (frame_tick) begin
            life_q  <= '0;
            state_q <= StFly;
          end
        end
        StFly: begin
          // A collision beats a same-cycle frame tick.
          if (hit) begin
            state_q <= StIdle;
          end else if (frame_tick) begin
            life_q <= life_inc;
            if (expire || off_screen) begin
              state_q <= StIdle;
            end else begin
              bullet_x_q <= step_x;
              bullet_y_q <= step_y;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = (state_q != StIdle);
  assign bullet_x    = bullet_x_q;
  assign bullet_y    = bullet_y_q;
  assign pixel_on    = pixel_on_q;
  assign pixel_index = pixel_index_q;

endmodule

// File: tb/tb_bullet_sprite_reader.sv
// Bench for bullet_sprite_reader: flight, bounds, collision, lifetime and the
// one-cycle pixel pipeline checked through a scoreboard queue.
module tb_bullet_sprite_reader;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick, fire, hit;
  logic       tick1, fire1;
  logic [9:0] tank_x, tank_y, DrawX, DrawY;
  logic [1:0] tank_dir, tank_sel;

  logic       busy0, pon0, busy1, pon1;
  logic [9:0] bx0, by0, bx1, by1;
  logic [3:0] pidx0, pidx1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic       on;
    logic [3:0] idx;
  } pix_t;
  pix_t sb[$];

  always #5 Clk = ~Clk;

  bullet_sprite_reader_if rom0 ();
  bullet_sprite_reader_if rom1 ();

  // Reference ROM contents: every fifth address carries palette index 4.
  function automatic logic [3:0] rom_model(input logic [13:0] a);
    return (a % 14'd5 == 14'd1) ? 4'd4 : 4'd0;
  endfunction

  assign rom0.rom_data = rom_model(rom0.rom_addr);
  assign rom1.rom_data = rom_model(rom1.rom_addr);

  bullet_sprite_reader u0 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .fire(fire), .hit(hit),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .tank_sel(tank_sel),
    .DrawX(DrawX), .DrawY(DrawY), .rom(rom0.master), .busy(busy0),
    .bullet_x(bx0), .bullet_y(by0), .pixel_on(pon0), .pixel_index(pidx0)
  );

  bullet_sprite_reader #(.LIFETIME(3)) u1 (
    .Clk(Clk), .Reset(Reset), .frame_tick(tick1), .fire(fire1), .hit(1'b0),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .tank_sel(tank_sel),
    .DrawX(DrawX), .DrawY(DrawY), .rom(rom1.master), .busy(busy1),
    .bullet_x(bx1), .bullet_y(by1), .pixel_on(pon1), .pixel_index(pidx1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick0();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic fire0(input int x, input int y, input int d, input int s);
    tank_x = 10'(x); tank_y = 10'(y); tank_dir = 2'(d); tank_sel = 2'(s);
    fire = 1'b1;
    step();
    fire = 1'b0;
  endtask

  // Drive one scan position against u0 at bullet (bx,by) in flight; check the address
  // now and the registered pixel one cycle later via the scoreboard.
  task automatic pix(input string tag, input int dx, input int dy, input int bx, input int by);
    logic        inb;
    logic [13:0] a;
    pix_t        e, got;
    DrawX = 10'(dx); DrawY = 10'(dy);
    #1;
    inb = (dx >= bx) && (dx < bx + 20) && (dy >= by) && (dy < by + 20);
    a   = inb ? 14'((dy - by) * 20 + (dx - bx)) : 14'd0;
    check({tag, "_addr"}, int'(rom0.rom_addr), int'(a));
    e.on  = inb && (rom_model(a) != 4'd0);
    e.idx = inb ? rom_model(a) : 4'd0;
    sb.push_back(e);
    step();
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      got = sb.pop_front();
      check({tag, "_on"}, int'(pon0), int'(got.on));
      check({tag, "_idx"}, int'(pidx0), int'(got.idx));
    end
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; fire = 1'b0; hit = 1'b0; tick1 = 1'b0; fire1 = 1'b0;
    tank_x = '0; tank_y = '0; tank_dir = '0; tank_sel = '0; DrawX = '0; DrawY = '0;
    step(); step();
    Reset = 1'b0;
    check("rst_busy", int'(busy0), 0);
    check("rst_pon", int'(pon0), 0);
    check("rst_bx", int'(bx0), 0);
    check("rst_addr", int'(rom0.rom_addr), 0);

    // Launch right from (100,200); the first tick only arms flight.
    fire0(100, 200, 1, 0);
    check("launch_busy", int'(busy0), 1);
    check("launch_bx", int'(bx0), 100);
    check("launch_by", int'(by0), 200);
    tick0();
    check("tick1_bx", int'(bx0), 100);
    pix("px_transp", 102, 201, 100, 200);
    pix("px_opaque", 106, 201, 100, 200);
    pix("px_outside", 120, 201, 100, 200);
    pix("px_corner", 119, 219, 100, 200);
    tick0();
    check("tick2_bx", int'(bx0), 104);
    tick0();
    check("tick3_bx", int'(bx0), 108);
    check("tick3_by", int'(by0), 200);

    fire0(300, 10, 2, 3);
    check("fire_fly_bx", int'(bx0), 108);
    check("fire_fly_sel", int'(rom0.rom_sel), 0);

    // Reset in flight while a visible pixel is being scanned.
    pix("px_pre_rst", 109, 201, 108, 200);
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    check("midrst_busy", int'(busy0), 0);
    check("midrst_pon", int'(pon0), 0);
    check("midrst_idx", int'(pidx0), 0);
    check("midrst_bx", int'(bx0), 0);
    check("midrst_addr", int'(rom0.rom_addr), 0);

    // Top edge: y=3 cannot move up by 4.
    fire0(100, 3, 0, 2);
    check("sel_pass", int'(rom0.rom_sel), 2);
    tick0();
    check("up_armed_busy", int'(busy0), 1);
    tick0();
    check("up_bound_busy", int'(busy0), 0);
    check("up_bound_by", int'(by0), 3);

    // Bottom edge: 456 -> 460 allowed, 464 would pass 460.
    fire0(100, 456, 2, 0);
    tick0(); tick0();
    check("down_by", int'(by0), 460);
    check("down_busy", int'(busy0), 1);
    tick0();
    check("down_bound_busy", int'(busy0), 0);
    check("down_bound_by", int'(by0), 460);

    // Hit and tick together in flight.
    fire0(200, 100, 1, 0);
    tick0();
    hit = 1'b1; frame_tick = 1'b1;
    step();
    hit = 1'b0; frame_tick = 1'b0;
    check("hit_busy", int'(busy0), 0);
    check("hit_bx", int'(bx0), 200);

    fire0(10, 10, 1, 0);
    hit = 1'b1;
    step();
    hit = 1'b0;
    check("hit_armed_busy", int'(busy0), 0);

    // Lifetime of 3 on the second instance.
    tank_x = 10'd50; tank_y = 10'd50; tank_dir = 2'b01; tank_sel = 2'b11;
    fire1 = 1'b1;
    step();
    fire1 = 1'b0;
    check("life_sel", int'(rom1.rom_sel), 3);
    for (int i = 0; i < 4; i++) begin
      tick1 = 1'b1;
      step();
      tick1 = 1'b0;
      step();
      if (i == 1) check("life_x54", int'(bx1), 54);
      if (i == 2) check("life_x58", int'(bx1), 58);
    end
    check("life_busy", int'(busy1), 0);
    check("life_bx", int'(bx1), 58);
    check("life_by", int'(by1), 50);
    check("life_sel_end", int'(rom1.rom_sel), 3);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
